// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit types, header layout and packet FSM encoding
package noc_pkg;

    localparam int FLIT_W = 34;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    localparam int HDR_DEST_LSB = 24;
    localparam int HDR_SRC_LSB  = 16;
    localparam int HDR_LEN_LSB  = 12;
    localparam int HDR_SEQ_LSB  = 0;
    localparam int SEQ_W        = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10,
        ST_TAIL = 2'b11
    } pkt_state_e;

endpackage

// File: rtl/noc_tag_unit.sv
// rtl/noc_tag_unit.sv - keyed rotate-xor integrity tag accumulator
module noc_tag_unit #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_seed,
    input  logic         accumulate,
    input  logic [W-1:0] word,
    input  logic [W-1:0] key,
    output logic [W-1:0] tag
);

    logic [W-1:0] tag_q;
    logic [W-1:0] tag_d;

    always_comb begin
        tag_d = tag_q;
        if (load_seed) begin
            tag_d = key;
        end else if (accumulate) begin
            tag_d = {tag_q[W-2:0], tag_q[W-1]} ^ word ^ key;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag = tag_q;

endmodule

// File: rtl/noc_flit_packetizer.sv
// rtl/noc_flit_packetizer.sv - wraps FIFO words into HEAD/BODY/TAIL flit packets
module noc_flit_packetizer
    import noc_pkg::*;
#(
    parameter int fifo_width = 32,
    parameter int len_bits   = 4,
    parameter int id_bits    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [fifo_width-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_deq,
    input  logic [id_bits-1:0]    dest_id,
    input  logic [id_bits-1:0]    src_id,
    input  logic [len_bits-1:0]   pkt_len,
    input  logic [fifo_width-1:0] key,
    output logic [fifo_width+1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  busy
);

    pkt_state_e            state_q, state_d;
    logic [id_bits-1:0]    dest_q, src_q;
    logic [len_bits-1:0]   len_q, cnt_q, cnt_d;
    logic [fifo_width-1:0] key_q;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  cfg_load;
    logic                  load_seed;
    logic                  accumulate;
    logic [fifo_width-1:0] tag;
    logic [fifo_width-1:0] tag_key;
    logic [fifo_width-1:0] header;

    // The seed comes straight from the key input in the cycle it is latched.
    assign tag_key = (state_q == ST_IDLE) ? key : key_q;

    noc_tag_unit #(.W(fifo_width)) u_tag (
        .clock      (clock),
        .reset      (reset),
        .load_seed  (load_seed),
        .accumulate (accumulate),
        .word       (fifo_data),
        .key        (tag_key),
        .tag        (tag)
    );

    always_comb begin
        header = '0;
        header[HDR_DEST_LSB +: id_bits] = dest_q;
        header[HDR_SRC_LSB  +: id_bits] = src_q;
        header[HDR_LEN_LSB  +: len_bits] = len_q;
        header[HDR_SEQ_LSB  +: SEQ_W]   = seq_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        cfg_load   = 1'b0;
        load_seed  = 1'b0;
        accumulate = 1'b0;
        fifo_deq   = 1'b0;
        flit_valid = 1'b0;
        flit_out   = '0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_valid) begin
                    cfg_load  = 1'b1;
                    load_seed = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_HEAD;
                end
            end
            ST_HEAD: begin
                flit_valid = 1'b1;
                flit_out   = {FLIT_HEAD, header};
                if (flit_ready) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                // A FIFO underrun simply stalls here; nothing is padded.
                flit_valid = fifo_valid;
                flit_out   = {FLIT_BODY, fifo_data};
                fifo_deq   = fifo_valid && flit_ready;
                if (fifo_deq) begin
                    accumulate = 1'b1;
                    cnt_d      = cnt_q + len_bits'(1);
                    if (cnt_q == len_q - len_bits'(1)) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                flit_valid = 1'b1;
                flit_out   = {FLIT_TAIL, tag};
                if (flit_ready) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            len_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            if (cfg_load) begin
                dest_q <= dest_id;
                src_q  <= src_id;
                len_q  <= pkt_len;
                key_q  <= key;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// tb/tb_noc_flit_packetizer.sv - directed and random packet checks against a packet-level model
module tb_noc_flit_packetizer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_deq;
    logic [7:0]  dest_id, src_id;
    logic [3:0]  pkt_len;
    logic [31:0] key;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] fq[$];
    logic [33:0] obs[$];
    logic [33:0] expq[$];
    logic [11:0] exp_seq;

    int          ready_mode;
    bit          gap_req, gap_done;
    int          gap_left, bp_left;
    logic [1:0]  bp_type;
    int          pops, deq_err, stab_err, gap_err;
    bit          prev_stall;
    logic [33:0] prev_f;
    int          cyc;

    noc_flit_packetizer dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_deq   (fifo_deq),
        .dest_id    (dest_id),
        .src_id     (src_id),
        .pkt_len    (pkt_len),
        .key        (key),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        n_asserts++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << 1) | (x >> 31);
    endfunction

    task automatic cycle();
        logic        v, d;
        logic [33:0] f;
        @(negedge clock);
        fifo_valid = (fq.size() != 0) && (gap_left == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
        #1;
        case (ready_mode)
            0: flit_ready = 1'b1;
            1: flit_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (flit_valid && flit_out[33:32] != bp_type) begin
                    bp_type = flit_out[33:32];
                    bp_left = 3;
                end
                flit_ready = (bp_left == 0);
                if (bp_left > 0) bp_left--;
            end
        endcase
        #1;
        v = flit_valid;
        f = flit_out;
        d = fifo_deq;
        if (d && !(v && flit_ready)) deq_err++;
        if (prev_stall && (!v || f !== prev_f)) stab_err++;
        if (gap_left > 0) begin
            if (v) gap_err++;
            gap_left--;
        end
        prev_stall = v && !flit_ready;
        prev_f     = f;
        if (busy) begin
            dest_id = 8'($urandom);
            src_id  = 8'($urandom);
            pkt_len = 4'($urandom);
            key     = $urandom;
        end
        if (v && flit_ready) obs.push_back(f);
        if (d && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        if (gap_req && !gap_done && obs.size() == 2) begin
            gap_left = 4;
            gap_done = 1'b1;
        end
        @(posedge clock);
    endtask

    task automatic run_packet(input logic [7:0] d_id, input logic [7:0] s_id, input logic [3:0] len,
                              input logic [31:0] k, input int mode, input bit gap, input int abort_at);
        int          n;
        logic [31:0] t;
        dest_id = d_id; src_id = s_id; pkt_len = len; key = k;
        ready_mode = mode; gap_req = gap; gap_done = 0; gap_left = 0;
        bp_left = 0; bp_type = 2'b11; prev_stall = 0;
        pops = 0; deq_err = 0; stab_err = 0; gap_err = 0;
        obs.delete();
        n = (len == 0) ? 16 : int'(len);
        expq.delete();
        expq.push_back({2'b01, d_id, s_id, len, exp_seq});
        t = k;
        for (int i = 0; i < n; i++) begin
            expq.push_back({2'b00, fq[i]});
            t = rotl(t) ^ fq[i] ^ k;
        end
        expq.push_back({2'b10, t});
        cyc = 0;
        while (cyc < 400 && !(obs.size() > 0 && obs[obs.size()-1][33:32] == 2'b10)
               && !(abort_at > 0 && obs.size() == abort_at)) begin
            cycle();
            cyc++;
        end
        chk("no_timeout", 64'(cyc < 400), 64'd1);
        if (abort_at > 0) begin
            #1;
            chk("pre_reset_valid", 64'(flit_valid), 64'd1);
            reset = 1'b1;
            #1;
            chk("rst_flit_valid", 64'(flit_valid), 64'd0);
            chk("rst_fifo_deq", 64'(fifo_deq), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_flit_out", 64'(flit_out), 64'd0);
            chk("abort_pops", 64'(pops), 64'(abort_at - 1));
            fifo_valid = 1'b0;
            #1;
            reset = 1'b0;
            exp_seq = 12'h000;
        end else begin
            chk("flit_count", 64'(obs.size()), 64'(n + 2));
            for (int i = 0; i < expq.size(); i++)
                chk($sformatf("flit%0d", i), (i < obs.size()) ? 64'(obs[i]) : 64'hx, 64'(expq[i]));
            chk("pops", 64'(pops), 64'(n));
            chk("deq_without_xfer", 64'(deq_err), 64'd0);
            chk("stall_stability", 64'(stab_err), 64'd0);
            chk("gap_valid", 64'(gap_err), 64'd0);
            if (mode == 0 && !gap) chk("duration", 64'(cyc), 64'(n + 3));
            exp_seq = exp_seq + 12'd1;
        end
    endtask

    initial begin
        reset = 1'b1; fifo_valid = 1'b1; fifo_data = 32'hdead_beef; flit_ready = 1'b1;
        dest_id = 0; src_id = 0; pkt_len = 0; key = 0;
        exp_seq = 12'h000;
        #2;
        chk("reset_flit_valid", 64'(flit_valid), 64'd0);
        chk("reset_fifo_deq", 64'(fifo_deq), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_flit_out", 64'(flit_out), 64'd0);
        @(negedge clock);
        @(negedge clock);
        fifo_valid = 1'b0;
        reset = 1'b0;

        fq.push_back(32'h1); fq.push_back(32'h1);
        run_packet(8'h05, 8'h02, 4'd2, 32'h0, 0, 0, 0);
        chk("basic_head", 64'(obs[0]), 64'h1_0502_2000);
        chk("basic_tail", 64'(obs[3]), 64'h2_0000_0003);

        fq.push_back(32'h1); fq.push_back(32'h1);
        run_packet(8'h05, 8'h02, 4'd2, 32'h0, 2, 0, 0);
        chk("bp_head_seq1", 64'(obs[0]), 64'h1_0502_2001);
        chk("bp_tail", 64'(obs[3]), 64'h2_0000_0003);

        for (int i = 0; i < 3; i++) fq.push_back($urandom);
        run_packet(8'h11, 8'h22, 4'd3, $urandom, 0, 1, 0);

        for (int i = 0; i < 16; i++) fq.push_back(32'(i));
        run_packet(8'hA0, 8'h0B, 4'd0, 32'hFFFF_FFFF, 0, 0, 0);
        chk("len0_hdr_len", 64'(obs[0][15:12]), 64'd0);

        for (int p = 0; p < 20; p++) begin
            logic [3:0] l;
            l = 4'($urandom);
            for (int i = 0; i < ((l == 0) ? 16 : int'(l)); i++) fq.push_back($urandom);
            run_packet(8'($urandom), 8'($urandom), l, $urandom, 1, 0, 0);
        end

        for (int i = 0; i < 4; i++) fq.push_back($urandom);
        run_packet(8'h33, 8'h44, 4'd4, $urandom, 0, 0, 2);
        chk("leftover_words", 64'(fq.size()), 64'd3);
        run_packet(8'h33, 8'h44, 4'd3, $urandom, 0, 0, 0);
        chk("post_reset_seq", 64'(obs[0][11:0]), 64'h000);

        while (exp_seq != 12'hFFF) begin
            fq.push_back($urandom);
            run_packet(8'($urandom), 8'($urandom), 4'd1, $urandom, 0, 0, 0);
        end
        fq.push_back($urandom);
        run_packet(8'h01, 8'h02, 4'd1, 32'h1234_5678, 0, 0, 0);
        chk("seq_fff", 64'(obs[0][11:0]), 64'hFFF);
        fq.push_back($urandom);
        run_packet(8'h01, 8'h02, 4'd1, 32'h1234_5678, 0, 0, 0);
        chk("seq_wrap", 64'(obs[0][11:0]), 64'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
